// File: rtl/rx_pkt_assembler_if.sv
// rx_pkt_assembler_if: bundle of the RX buffer read port and the data link
// layer valid/ready stream seen by rx_pkt_assembler.
// master = the assembler itself, slave = the surrounding environment.
interface rx_pkt_assembler_if #(
  parameter int DATA_WIDTH       = 256,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int CNT_WIDTH        = 16
);
  // RX buffer read side
  logic                        i_Empty;
  logic                        o_RD_EN;
  logic [0:DATA_WIDTH-1]       i_Data;
  logic                        i_SOP;
  logic                        i_End_Valid;
  logic                        i_Type;
  logic [PACKET_LENGTH-1:0]    i_Length;
  logic [SYMBOL_PTR_WIDTH-1:0] i_Last_Byte;
  // data link layer side
  logic                        o_Valid;
  logic                        i_Ready;
  logic [0:DATA_WIDTH-1]       o_Data;
  logic                        o_SOP;
  logic                        o_EOP;
  logic                        o_Type;
  logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte;
  logic                        o_Drop;
  logic                        o_Len_Err;
  logic                        o_Frame_Err;
  logic [CNT_WIDTH-1:0]        o_Pkt_Cnt;

  modport master (
    input  i_Empty, i_Data, i_SOP, i_End_Valid, i_Type, i_Length, i_Last_Byte, i_Ready,
    output o_RD_EN, o_Valid, o_Data, o_SOP, o_EOP, o_Type, o_Last_Byte, o_Drop,
           o_Len_Err, o_Frame_Err, o_Pkt_Cnt
  );

  modport slave (
    output i_Empty, i_Data, i_SOP, i_End_Valid, i_Type, i_Length, i_Last_Byte, i_Ready,
    input  o_RD_EN, o_Valid, o_Data, o_SOP, o_EOP, o_Type, o_Last_Byte, o_Drop,
           o_Len_Err, o_Frame_Err, o_Pkt_Cnt
  );
endinterface

// File: rtl/rx_pkt_assembler.sv
// rx_pkt_assembler: pops beats from the RX buffer, checks TLP framing and
// length, and forwards the stream through a skid FIFO sized so that reads
// are only issued when a free slot is guaranteed for the returning beat.
module rx_pkt_assembler #(
  parameter int DATA_WIDTH       = 256,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int SKID_DEPTH       = 4,
  parameter int CNT_WIDTH        = 16
) (
  input logic                CLK,
  input logic                RST,
  input logic                Soft_RST_blocks,
  rx_pkt_assembler_if.master bus
);

  localparam int PTR_W   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W   = PTR_W + 1;
  localparam int DWC_W   = 12;
  localparam int BEAT_DW = DATA_WIDTH / 32;
  localparam logic [DWC_W-1:0] DWC_MAX  = '1;
  localparam logic [OCC_W:0]   RD_LIMIT = (OCC_W+1)'(SKID_DEPTH - 1);

  typedef enum logic {IDLE, IN_PKT} state_t;

  // Saturating DW accumulator so an oversize packet cannot wrap into a match.
  function automatic logic [DWC_W-1:0] sat_add(input logic [DWC_W-1:0] a,
                                               input logic [DWC_W-1:0] b);
    logic [DWC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DWC_W] ? DWC_MAX : s[DWC_W-1:0];
  endfunction

  // DW carried by one beat: full beat, or up to and including the last byte.
  function automatic logic [DWC_W-1:0] beat_dw(input logic is_end,
                                               input logic [SYMBOL_PTR_WIDTH-1:0] lb);
    logic [SYMBOL_PTR_WIDTH-1:0] sh;
    sh = lb >> 2;
    if (is_end) return DWC_W'(sh) + DWC_W'(1);
    return DWC_W'(BEAT_DW);
  endfunction

  // A TLP fails if its DW count disagrees with the header or ends mid-DW.
  function automatic logic len_fail(input logic                     is_tlp,
                                    input logic [DWC_W-1:0]         cnt,
                                    input logic [PACKET_LENGTH-1:0] len,
                                    input logic [1:0]               lb_lo);
    return is_tlp && ((cnt != DWC_W'(len)) || (lb_lo != 2'b11));
  endfunction

  logic                     rst_any;
  state_t                   state, state_nxt;
  logic                     vld_p1;
  logic [OCC_W-1:0]         occ;
  logic [OCC_W:0]           occ_sum;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [DWC_W-1:0]         dw_cnt, dw_cnt_nxt, bdw, acc;
  logic [PACKET_LENGTH-1:0] len_lat, len_nxt;
  logic                     type_lat, type_nxt;
  logic                     wr_en, wr_type, wr_drop;
  logic                     len_err_nxt, frame_err_nxt;
  logic                     len_err_p2, frame_err_p2;
  logic                     rd_en, pop, head_vld;
  logic [CNT_WIDTH-1:0]     pkt_cnt;

  logic [0:DATA_WIDTH-1]       mem_data [SKID_DEPTH];
  logic                        mem_sop  [SKID_DEPTH];
  logic                        mem_eop  [SKID_DEPTH];
  logic                        mem_type [SKID_DEPTH];
  logic                        mem_drop [SKID_DEPTH];
  logic [SYMBOL_PTR_WIDTH-1:0] mem_lb   [SKID_DEPTH];

  assign rst_any  = RST | Soft_RST_blocks;
  assign occ_sum  = {1'b0, occ} + {{OCC_W{1'b0}}, vld_p1};
  assign rd_en    = !rst_any && !bus.i_Empty && (occ_sum <= RD_LIMIT);
  assign head_vld = (occ != '0);
  assign pop      = head_vld && bus.i_Ready;
  assign bdw      = beat_dw(bus.i_End_Valid, bus.i_Last_Byte);
  assign acc      = sat_add(dw_cnt, bdw);

  // Intake decode: classify the returning beat, update the packet tally, decide write/drop/errors.
  always_comb begin
    state_nxt     = state;
    dw_cnt_nxt    = dw_cnt;
    len_nxt       = len_lat;
    type_nxt      = type_lat;
    wr_en         = 1'b0;
    wr_type       = type_lat;
    wr_drop       = 1'b0;
    frame_err_nxt = 1'b0;
    if (vld_p1) begin
      if (bus.i_SOP) begin
        // A new SOP always opens a packet; inside an open packet it also aborts it.
        frame_err_nxt = (state == IN_PKT);
        wr_en         = 1'b1;
        len_nxt       = bus.i_Length;
        type_nxt      = bus.i_Type;
        wr_type       = bus.i_Type;
        dw_cnt_nxt    = bdw;
        if (bus.i_End_Valid) begin
          wr_drop   = len_fail(bus.i_Type, bdw, bus.i_Length, bus.i_Last_Byte[1:0]);
          state_nxt = IDLE;
        end else begin
          state_nxt = IN_PKT;
        end
      end else if (state == IN_PKT) begin
        wr_en      = 1'b1;
        dw_cnt_nxt = acc;
        if (bus.i_End_Valid) begin
          wr_drop   = len_fail(type_lat, acc, len_lat, bus.i_Last_Byte[1:0]);
          state_nxt = IDLE;
        end
      end else begin
        // Continuation beat with no open packet: discarded, never written.
        frame_err_nxt = 1'b1;
      end
    end
    len_err_nxt = wr_drop;
  end

  // Control state: FSM, read pipeline, FIFO pointers/occupancy, error pulses, good-packet count.
  always_ff @(posedge CLK) begin
    if (rst_any) begin
      state        <= IDLE;
      vld_p1       <= 1'b0;
      occ          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      dw_cnt       <= '0;
      len_lat      <= '0;
      type_lat     <= 1'b0;
      len_err_p2   <= 1'b0;
      frame_err_p2 <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      // read issued -> beat on i_* next cycle
      vld_p1       <= rd_en;
      // capture -> error pulses one cycle later
      state        <= state_nxt;
      dw_cnt       <= dw_cnt_nxt;
      len_lat      <= len_nxt;
      type_lat     <= type_nxt;
      len_err_p2   <= len_err_nxt;
      frame_err_p2 <= frame_err_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (pop && mem_eop[rd_ptr] && !mem_drop[rd_ptr]) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
    end
  end

  // Skid FIFO storage; contents are don't-care until occupancy covers them.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= bus.i_Data;
      mem_sop[wr_ptr]  <= bus.i_SOP;
      mem_eop[wr_ptr]  <= bus.i_End_Valid;
      mem_type[wr_ptr] <= wr_type;
      mem_drop[wr_ptr] <= wr_drop;
      mem_lb[wr_ptr]   <= bus.i_End_Valid ? bus.i_Last_Byte : '0;
    end
  end

  // Head entry drives the stream; everything reads zero while the FIFO is empty.
  assign bus.o_RD_EN     = rd_en;
  assign bus.o_Valid     = head_vld;
  assign bus.o_Data      = head_vld ? mem_data[rd_ptr] : '0;
  assign bus.o_SOP       = head_vld && mem_sop[rd_ptr];
  assign bus.o_EOP       = head_vld && mem_eop[rd_ptr];
  assign bus.o_Type      = head_vld && mem_type[rd_ptr];
  assign bus.o_Drop      = head_vld && mem_drop[rd_ptr];
  assign bus.o_Last_Byte = head_vld ? mem_lb[rd_ptr] : '0;
  assign bus.o_Len_Err   = len_err_p2;
  assign bus.o_Frame_Err = frame_err_p2;
  assign bus.o_Pkt_Cnt   = pkt_cnt;

endmodule
